// File: rtl/rosc_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rosc_meter_pkg
//  Purpose  : Shared types and default sizing for the ring-oscillator
//             frequency meter (FSM state encoding, default parameters).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rosc_meter_pkg;

    localparam int DEF_WIN_W       = 16;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Explicitly encoded 2-bit measurement state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : rosc_meter_pkg
`default_nettype wire

// File: rtl/rosc_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : rosc_sync_edge
//  Purpose  : Multi-flop synchronizer for the asynchronous oscillator output
//             followed by a rising-edge detector in the axi_clk domain.
//  Ports    : axi_clk  - clock
//             resetb   - asynchronous active-low reset
//             d_async  - asynchronous input
//             rise     - one-cycle pulse on a synchronized 0->1 transition
//  Revision : 1.0 - initial release
// ============================================================================
module rosc_sync_edge #(
    parameter int SYNC_STAGES = rosc_meter_pkg::DEF_SYNC_STAGES
) (
    input  logic axi_clk,
    input  logic resetb,
    input  logic d_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // The edge-history flop updates every cycle regardless of the meter
    // state, so a transition that happened before counting starts is never
    // reported late.
    always_ff @(posedge axi_clk or negedge resetb) begin
        if (!resetb) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : rosc_sync_edge
`default_nettype wire

// File: rtl/rosc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : rosc_freq_meter
//  Purpose  : Enables the ring-oscillator clock gate, waits a settle
//             interval, then counts rising edges of the gated oscillator
//             output over a programmable window of axi_clk cycles.
//  Ports    : axi_clk  - sole clock
//             resetb   - asynchronous active-low reset
//             start    - measurement request (accepted only when idle)
//             abort    - cancel measurement in progress
//             win_len  - window length in axi_clk cycles
//             freq_in  - gated oscillator output (asynchronous)
//             rosc_en  - oscillator clock-gate enable
//             busy     - high whenever a measurement is in flight
//             done     - one-cycle pulse, count valid
//             count    - edges counted in last window
//             overflow - count saturated during this measurement
//  Revision : 1.0 - initial release
// ============================================================================
module rosc_freq_meter #(
    parameter int WIN_W       = rosc_meter_pkg::DEF_WIN_W,
    parameter int CNT_W       = rosc_meter_pkg::DEF_CNT_W,
    parameter int SETTLE_CYC  = rosc_meter_pkg::DEF_SETTLE_CYC,
    parameter int SYNC_STAGES = rosc_meter_pkg::DEF_SYNC_STAGES
) (
    input  logic             axi_clk,
    input  logic             resetb,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             freq_in,
    output logic             rosc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    import rosc_meter_pkg::*;

    localparam int c_SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

    state_t             r_state,      w_state_nxt;
    logic [WIN_W-1:0]   r_win_len,    w_win_len_nxt;
    logic [WIN_W-1:0]   r_win_cnt,    w_win_cnt_nxt;
    logic [c_SET_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [CNT_W-1:0]   r_count,      w_count_nxt;
    logic               r_overflow,   w_overflow_nxt;
    logic               r_rosc_en,    w_rosc_en_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_done,       w_done_nxt;
    logic               w_rise;

    rosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .axi_clk (axi_clk),
        .resetb  (resetb),
        .d_async (freq_in),
        .rise    (w_rise)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_win_len_nxt    = r_win_len;
        w_win_cnt_nxt    = r_win_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_count_nxt      = r_count;
        w_overflow_nxt   = r_overflow;
        w_rosc_en_nxt    = r_rosc_en;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_rosc_en_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    w_count_nxt    = '0;
                    w_overflow_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    if (win_len != '0) begin
                        w_win_len_nxt    = win_len;
                        // counts down to zero; SETTLE_CYC cycles in total
                        w_settle_cnt_nxt = c_SET_W'(SETTLE_CYC - 1);
                        w_rosc_en_nxt    = 1'b1;
                        w_state_nxt      = ST_SETTLE;
                    end else begin
                        // empty window: report immediately, gate stays off
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    w_rosc_en_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else if (r_settle_cnt == '0) begin
                    w_win_cnt_nxt = r_win_len - WIN_W'(1);
                    w_state_nxt   = ST_COUNT;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - c_SET_W'(1);
                end
            end

            ST_COUNT: begin
                if (abort) begin
                    w_rosc_en_nxt = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    if (w_rise) begin
                        if (&r_count) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + CNT_W'(1);
                        end
                    end
                    if (r_win_cnt == '0) begin
                        w_rosc_en_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = ST_DONE;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt - WIN_W'(1);
                    end
                end
            end

            ST_DONE: begin
                // abort is ignored here so the done pulse always completes
                w_rosc_en_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = ST_IDLE;
            end

            default: begin
                w_rosc_en_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= ST_IDLE;
            r_win_len    <= '0;
            r_win_cnt    <= '0;
            r_settle_cnt <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_rosc_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_len    <= w_win_len_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_count      <= w_count_nxt;
            r_overflow   <= w_overflow_nxt;
            r_rosc_en    <= w_rosc_en_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign rosc_en  = r_rosc_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule : rosc_freq_meter
`default_nettype wire
